spin_arbiter: RTL and testbench
===============================

Name: spin_arbiter

Overview:
Round-robin scheduler that shares one combinational 32-bit right-rotator (the spinner datapath) among NREQ requesters.
- Accepts one rotate job at a time over a valid/ready handshake.
- Drives the rotator's data and amount inputs from internal registers.
- Feeds the rotator output back `count` times, so the net rotation is amount*count mod 32.
- Returns the result with the requester's id over a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNTW, 4, width of the per-job pass count.
- IDW, 2, width of res_id; must equal clog2(NREQ).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  one-hot acceptance; at most one bit high.
- req_data  in  NREQ*32  job data; slice i is requester i.
- req_amount  in  NREQ*5  rotate-right amount per pass; slice i.
- req_count  in  NREQ*CNTW  number of passes; slice i; 0 is treated as 1.
- rot_din  out  32  to rotator data input.
- rot_amount  out  5  to rotator amount input.
- rot_dout  in  32  rotator result, combinational: rot_din rotated right by rot_amount.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  rotated result.
- res_id  out  IDW  index of the requester that owns res_data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Registers: state, data_r[31:0], amt_r[4:0], rem_r[CNTW-1:0], id_r, ptr (round-robin pointer).
- Reset (asynchronous, takes effect immediately, including mid-job):
  - state=IDLE; data_r=0; amt_r=0; rem_r=0; id_r=0; ptr=0.
  - All outputs 0; any in-flight job is discarded and not reported.
- Output mapping:
  - rot_din=data_r; rot_amount=amt_r.
  - res_data=data_r; res_id=id_r.
  - res_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - The grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1; this is combinational from req_valid and ptr, and only in IDLE.
  - On the edge, if any request is valid:
    - data_r=req_data[g]; amt_r=req_amount[g]; id_r=g.
    - rem_r=req_count[g], or 1 if req_count[g]=0.
    - ptr=(g+1) mod NREQ; state=BUSY.
  - With no valid request: hold.
- BUSY:
  - Each edge: data_r=rot_dout and rem_r=rem_r-1.
  - When rem_r==1 on that edge, state=DONE.
  - req_ready is all zeros throughout BUSY.
- DONE:
  - res_valid=1; data_r and id_r hold until res_ready=1.
  - On the edge with res_ready=1: state=IDLE. No new job is accepted in that same cycle; acceptance resumes the next cycle.
- Latency: accept on edge E0; passes on edges E1..En (n = effective count); res_valid goes high after En.
  - Minimum accept-to-accept period for back-to-back jobs with res_ready held high: n+2 cycles.
- Boundaries:
  - amount=0 yields identity regardless of count.
  - count=2^CNTW-1 gives the maximum pass count.
  - rem_r never underflows.
  - A requester that drops req_valid while not granted loses nothing.
  - req_valid changing during BUSY or DONE has no effect.
  - The pointer advances only on accept, so a requester that was skipped is served within NREQ grants.

Test Plan:
1. After reset, id0 valid with data=0x00000001, amount=1, count=1, res_ready=1 → req_ready=4'b0001 for one cycle; res_valid=1 with res_data=0x80000000 and res_id=0 on the cycle after E1; back to IDLE.
2. id2 with data=0x12345678, amount=8, count=3 → rot_din steps 0x12345678, 0x78123456, 0x56781234; res_data=0x34567812 and res_id=2, 3 cycles after accept.
3. id1 with data=0xA5A5A5A5, amount=4, count=0 → treated as one pass; res_data=0x5A5A5A5A.
4. All four req_valid held high, res_ready=1, each count=1 → grant order 0,1,2,3,0; each accept 3 cycles apart; busy is low only in the accept cycles.
5. Job done with res_ready=0 for 5 cycles → res_valid stays 1; res_data and res_id are stable; req_ready stays 0; the job completes on the res_ready=1 edge.
6. reset_n pulsed low mid-BUSY (count=10, after 4 passes) → all outputs 0 immediately; no res_valid; the next accept grants starting from id0.

Source files
------------

// File: rtl/spin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spin_arbiter
// Description : Round-robin scheduler sharing one external 32-bit right
//               rotator among NREQ requesters; multi-pass rotate jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module spin_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 4,
    parameter int IDW  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic [NREQ*5-1:0]    req_amount,
    input  logic [NREQ*CNTW-1:0] req_count,
    output logic [31:0]          rot_din,
    output logic [4:0]           rot_amount,
    input  logic [31:0]          rot_dout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     data_r;
    logic [4:0]      amt_r;
    logic [CNTW-1:0] rem_r;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  ptr;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    int              scan_idx;
    logic [31:0]     sel_data;
    logic [4:0]      sel_amount;
    logic [CNTW-1:0] sel_count;
    logic [IDW-1:0]  ptr_next;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        sel_data   = req_data[int'(grant_idx)*32 +: 32];
        sel_amount = req_amount[int'(grant_idx)*5 +: 5];
        sel_count  = req_count[int'(grant_idx)*CNTW +: CNTW];
        ptr_next   = IDW'((int'(grant_idx) + 1) % NREQ);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = BUSY;
            BUSY:    if (rem_r <= CNTW'(1)) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= '0;
            amt_r  <= '0;
            rem_r  <= '0;
            id_r   <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        data_r <= sel_data;
                        amt_r  <= sel_amount;
                        id_r   <= grant_idx;
                        rem_r  <= (sel_count == '0) ? CNTW'(1) : sel_count;
                        ptr    <= ptr_next;
                    end
                end
                BUSY: begin
                    data_r <= rot_dout;
                    // Saturating decrement keeps the counter from wrapping.
                    if (rem_r != '0) begin
                        rem_r <= rem_r - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gating keeps every output at zero while reset is asserted.
    assign req_ready  = (state == IDLE && grant_found && reset_n)
                        ? (NREQ'(1) << grant_idx) : '0;
    assign rot_din    = data_r;
    assign rot_amount = amt_r;
    assign res_data   = data_r;
    assign res_id     = id_r;
    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spin_arbiter
// Description : Self-checking bench for spin_arbiter with a closed-form model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spin_arbiter;
    localparam int NREQ = 4;
    localparam int CNTW = 4;
    localparam int IDW  = 2;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_data = '0;
    logic [NREQ*5-1:0]    req_amount = '0;
    logic [NREQ*CNTW-1:0] req_count = '0;
    logic [31:0]          rot_din;
    logic [4:0]           rot_amount;
    logic [31:0]          rot_dout;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [31:0]          res_data;
    logic [IDW-1:0]       res_id;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    spin_arbiter #(.NREQ(NREQ), .CNTW(CNTW), .IDW(IDW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amount(req_amount), .req_count(req_count),
        .rot_din(rot_din), .rot_amount(rot_amount), .rot_dout(rot_dout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        logic [63:0] d;
        d = {x, x} >> (s % 32);
        return d[31:0];
    endfunction

    assign rot_dout = rotr(rot_din, int'(rot_amount));

    function automatic int grant_of(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a job is (start cycle, pass count); outputs follow in closed form.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_a = 0;
    int          m_n = 0;
    logic [31:0] m_d0 = '0;
    logic [31:0] m_hold = '0;
    logic [4:0]  m_amt = '0;
    int          m_id = 0;
    int          m_ptr = 0;
    int          m_before;
    int          m_g;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_hold = '0; m_amt = '0; m_id = 0; m_ptr = 0; m_n = 0;
        end else begin
            m_before = cyc;
            cyc++;
            if (m_active) begin
                if (m_before - m_a >= m_n && res_ready) begin
                    m_active = 0;
                    m_hold   = rotr(m_d0, int'(m_amt) * m_n);
                end
            end else begin
                m_g = grant_of(req_valid, m_ptr);
                if (m_g >= 0) begin
                    m_active = 1;
                    m_a      = cyc;
                    m_id     = m_g;
                    m_d0     = req_data[m_g*32 +: 32];
                    m_amt    = req_amount[m_g*5 +: 5];
                    m_n      = int'(req_count[m_g*CNTW +: CNTW]);
                    if (m_n == 0) m_n = 1;
                    m_ptr    = (m_g + 1) % NREQ;
                end
            end
        end
    end

    int               c_p;
    int               c_g;
    logic [31:0]      e_din;
    logic [NREQ-1:0]  e_rdy;
    logic             e_rv;
    logic             e_busy;

    always @(negedge clock) begin
        if (!m_active) begin
            e_busy = 1'b0;
            e_rv   = 1'b0;
            e_din  = m_hold;
            c_g    = grant_of(req_valid, m_ptr);
            e_rdy  = (reset_n && c_g >= 0) ? NREQ'(1) << c_g : '0;
        end else begin
            c_p    = cyc - m_a;
            e_rv   = (c_p >= m_n);
            if (c_p > m_n) c_p = m_n;
            e_din  = rotr(m_d0, int'(m_amt) * c_p);
            e_busy = 1'b1;
            e_rdy  = '0;
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("rot_din", rot_din, e_din);
        chk("res_data", res_data, e_din);
        chk("rot_amount", 32'(rot_amount), 32'(m_amt));
        chk("res_id", 32'(res_id), 32'(m_id));
    end

    task automatic set_job(input int i, input logic [31:0] d, input logic [4:0] a,
                           input logic [CNTW-1:0] c);
        req_data[i*32 +: 32]     = d;
        req_amount[i*5 +: 5]     = a;
        req_count[i*CNTW +: CNTW] = c;
    endtask

    // Present one job, let it be accepted, then wait (bounded) for its result.
    task automatic run_job(input int i, input logic [31:0] d, input logic [4:0] a,
                           input logic [CNTW-1:0] c, output int waited,
                           output logic [31:0] trace [4]);
        @(posedge clock); #1;
        set_job(i, d, a, c);
        req_valid = NREQ'(1) << i;
        @(posedge clock); #1;
        req_valid = '0;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            waited++;
            if (k < 4) trace[k] = rot_din;
            if (res_valid) break;
        end
        if (!res_valid) chk("result_timeout", 32'(res_valid), 32'd1);
    endtask

    logic [31:0] tr [4];
    int          waited;
    int          grants[$];
    int          gcyc[$];
    logic [31:0] held;

    initial begin
        for (int k = 0; k < 4; k++) tr[k] = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_rot_din", rot_din, 32'd0);

        // Single pass, amount 1.
        @(posedge clock); #1;
        set_job(0, 32'h0000_0001, 5'd1, 4'd1);
        req_valid = 4'b0001;
        @(negedge clock);
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        @(posedge clock); #1;
        req_valid = '0;
        @(negedge clock);
        chk("t1_not_yet", 32'(res_valid), 32'd0);
        @(negedge clock);
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_data", res_data, 32'h8000_0000);
        chk("t1_res_id", 32'(res_id), 32'd0);
        @(negedge clock);
        chk("t1_back_idle", 32'(busy), 32'd0);

        // Three passes of 8.
        run_job(2, 32'h1234_5678, 5'd8, 4'd3, waited, tr);
        chk("t2_step0", tr[0], 32'h1234_5678);
        chk("t2_step1", tr[1], 32'h7812_3456);
        chk("t2_step2", tr[2], 32'h5678_1234);
        chk("t2_res_data", res_data, 32'h3456_7812);
        chk("t2_res_id", 32'(res_id), 32'd2);
        chk("t2_latency", 32'(waited), 32'd4);

        // Count zero behaves as one pass.
        run_job(1, 32'hA5A5_A5A5, 5'd4, 4'd0, waited, tr);
        chk("t3_res_data", res_data, 32'h5A5A_5A5A);
        chk("t3_latency", 32'(waited), 32'd2);

        // Fairness with everybody requesting after a fresh reset.
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_job(i, 32'h1000_0000 * (i + 1), 5'(i + 3), 4'd1);
        req_valid = 4'hF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin grants.push_back(i); gcyc.push_back(k); end
        end
        @(posedge clock); #1;
        req_valid = '0;
        chk("t4_grant_count", 32'(grants.size()), 32'd5);
        if (grants.size() >= 5) begin
            chk("t4_g0", 32'(grants[0]), 32'd0);
            chk("t4_g1", 32'(grants[1]), 32'd1);
            chk("t4_g2", 32'(grants[2]), 32'd2);
            chk("t4_g3", 32'(grants[3]), 32'd3);
            chk("t4_g4", 32'(grants[4]), 32'd0);
            chk("t4_period", 32'(gcyc[4] - gcyc[3]), 32'd3);
        end
        repeat (4) @(posedge clock);

        // Consumer stalls for five cycles.
        res_ready = 1'b0;
        run_job(3, 32'hDEAD_BEEF, 5'd12, 4'd2, waited, tr);
        chk("t5_res_data", res_data, 32'hADBE_EFDE);
        held = res_data;
        @(posedge clock); #1;
        req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t5_hold_valid", 32'(res_valid), 32'd1);
            chk("t5_hold_data", res_data, held);
            chk("t5_hold_id", 32'(res_id), 32'd3);
            chk("t5_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
        req_valid = '0;
        @(posedge clock); #1;
        chk("t5_released", 32'(res_valid), 32'd0);

        // Reset in the middle of a long job.
        run_job_start(2);
        repeat (4) @(posedge clock);
        #1;
        req_valid = 4'hF;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_rot_din", rot_din, 32'd0);
        chk("t6_rot_amount", 32'(rot_amount), 32'd0);
        chk("t6_res_id", 32'(res_id), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("t6_regrant", 32'(req_ready), 32'h1);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (20) @(posedge clock);

        // Randomised traffic, stalls and occasional resets.
        for (int t = 0; t < 3000; t++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
            end else begin
                reset_n = 1'b1;
            end
            req_valid = NREQ'($urandom) & NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                set_job(i, $urandom, 5'($urandom),
                        ($urandom_range(0, 9) == 0) ? 4'd0 :
                        ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(1, 5)));
            end
            res_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (40) @(posedge clock);
        @(negedge clock);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic run_job_start(input int i);
        res_ready = 1'b1;
        @(posedge clock); #1;
        set_job(i, 32'hCAFE_F00D, 5'd3, 4'd10);
        req_valid = NREQ'(1) << i;
        @(posedge clock); #1;
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
